sram_responder: RTL and testbench
=================================

SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter SHALL be: ADDR_BASE, 32'h80000000, byte address of storage word 0.
REQ-002 Parameter SHALL be: DEPTH_LOG2, 12, log2 of storage depth in 32-bit words.
REQ-003 Parameter SHALL be: LATENCY, 1, cycles from request handshake to first rsp_valid (legal 1..15).
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  responder accepts request this cycle.
REQ-008 req_wen  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  write data, lane i = bits 8i+7:8i of the addressed word.
REQ-011 req_wmask  input  4  write byte enables.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  requester accepts response.
REQ-014 rsp_rdata  output  32  full read word (requester performs byte/half extraction and sign extension).
REQ-015 rsp_err  output  1  access fault.

Function
REQ-016 FSM SHALL have states IDLE, BUSY, RESP; one outstanding request only.
REQ-017 req_ready SHALL be 1 only in IDLE and not in reset; 0 in BUSY and RESP.
REQ-018 Handshake on req_valid && req_ready SHALL capture wen, addr, wdata, wmask; request inputs are ignored at all other times.
REQ-019 rsp_valid SHALL rise exactly LATENCY cycles after the handshake edge (LATENCY=1: BUSY skipped, RESP entered on the next edge); BUSY uses a 4-bit down-counter.
REQ-020 The memory access (read sample, write commit) SHALL occur on the edge entering RESP.
REQ-021 In range: ADDR_BASE <= addr and (addr - ADDR_BASE) < 4<<DEPTH_LOG2; word index = (addr - ADDR_BASE)[DEPTH_LOG2+1:2]; addr[1:0] ignored.
REQ-022 Out-of-range access SHALL give rsp_err=1, rsp_rdata=0, and no storage change.
REQ-023 Write SHALL update only the bytes with wmask[i]=1; wmask=4'b0000 is a legal no-op (rsp_err=0); write response rsp_rdata=0.
REQ-024 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready=1; on rsp_valid && rsp_ready the FSM returns to IDLE and the next handshake is possible one cycle later.
REQ-025 A read issued after a committed write to the same word SHALL return the merged written data.

Reset
REQ-026 While rst=1: state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0.
REQ-027 Reset mid-operation: an uncommitted (BUSY) write SHALL be dropped; already committed writes persist; the pending response is discarded.
REQ-028 Storage contents are not reset (undefined until written).

Configuration
REQ-029 Macro SRAM_RESPONDER_RAND_DELAY_EN defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'h5A on reset) advances every cycle; on handshake the extra delay = lfsr[2:0] (0..7) is added to LATENCY.
REQ-030 Macro undefined: latency is exactly LATENCY, no LFSR logic is present, and all other behaviour is identical.

Verification
REQ-031 Reset, write addr 32'h80000010 wdata 32'hDEADBEEF wmask 4'hF, then read the same address -> rsp_rdata 32'hDEADBEEF, rsp_err 0, rsp_valid exactly LATENCY cycles after each handshake.
REQ-032 Word 32'hDEADBEEF, write addr 32'h80000012 wdata 32'h00AA0000 wmask 4'b0100, then read -> 32'hDEAABEEF.
REQ-033 Read addr 32'h7FFFFFFC and 32'h80004000 (DEPTH_LOG2=12) -> rsp_err 1, rsp_rdata 0; a following in-range read is unaffected.
REQ-034 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready 0; rsp_ready=1 -> IDLE; back-to-back requests with rsp_ready tied to 1 -> one response per LATENCY+1 cycles.
REQ-035 LATENCY=4, write to 32'h80000020 data 32'h12345678, assert rst in BUSY -> rsp_valid never rises; a later read of 32'h80000020 does not return 32'h12345678 unless it was previously stored there.
REQ-036 With SRAM_RESPONDER_RAND_DELAY_EN, 200 random requests against a reference model -> data matches, delay within LATENCY..LATENCY+7, rsp_valid never asserted without a prior handshake.

Source files
------------

// File: rtl/sram_responder.sv
// sram_responder: single-outstanding request/response wrapper around a
// word-addressed 32-bit storage array with byte write enables.
// The response arrives LATENCY cycles after the request handshake.
// Optional feature macro: SRAM_RESPONDER_RAND_DELAY_EN adds a pseudo-random
// 0..7 cycle extra delay drawn from an 8-bit LFSR.
module sram_responder #(
    parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned LATENCY    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
`ifdef SRAM_RESPONDER_RAND_DELAY_EN
    // LATENCY (up to 15) plus up to 7 extra cycles needs a 5-bit count
    localparam int unsigned CW = 5;
`else
    localparam int unsigned CW = 4;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic           cap_wen;
    logic [31:0]    cap_addr;
    logic [31:0]    cap_wdata;
    logic [3:0]     cap_wmask;
    logic [31:0]    mem [DEPTH];

    logic           handshake;
    logic [CW-1:0]  delay;
    logic           acc_wen;
    logic [31:0]    acc_addr;
    logic [31:0]    acc_wdata;
    logic [3:0]     acc_wmask;
    logic [31:0]    off;
    logic           in_range;
    logic [DEPTH_LOG2-1:0] widx;
    logic           to_resp;
    logic           commit;

`ifdef SRAM_RESPONDER_RAND_DELAY_EN
    logic [7:0]     lfsr;

    // Fibonacci LFSR, taps 8,6,5,4; free-running outside reset
    always_ff @(posedge clk) begin
        if (rst) lfsr <= 8'h5A;
        else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign delay = CW'(LATENCY) + CW'(lfsr[2:0]);
`else
    assign delay = CW'(LATENCY);
`endif

    assign handshake = req_valid && req_ready;

    // With a one-cycle delay the access happens on the handshake edge itself,
    // so the live request fields are used while still in IDLE.
    assign acc_wen   = (state == IDLE) ? req_wen   : cap_wen;
    assign acc_addr  = (state == IDLE) ? req_addr  : cap_addr;
    assign acc_wdata = (state == IDLE) ? req_wdata : cap_wdata;
    assign acc_wmask = (state == IDLE) ? req_wmask : cap_wmask;

    assign off      = acc_addr - ADDR_BASE;
    assign in_range = (acc_addr >= ADDR_BASE) && ({1'b0, off} < (33'd4 << DEPTH_LOG2));
    assign widx     = off[DEPTH_LOG2+1:2];

    assign to_resp = ((state == IDLE) && handshake && (delay == CW'(1))) ||
                     ((state == BUSY) && (cnt == '0));
    assign commit  = to_resp && !rst && acc_wen && in_range;

    // Byte-masked write commit on the edge that enters RESP; storage is never reset
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (acc_wmask[i]) mem[widx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

    // Request/response FSM with registered handshake and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (to_resp) begin
                state     <= RESP;
                rsp_valid <= 1'b1;
                rsp_err   <= !in_range;
                rsp_rdata <= (in_range && !acc_wen) ? mem[widx] : '0;
            end
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (handshake) begin
                        req_ready <= 1'b0;
                        cap_wen   <= req_wen;
                        cap_addr  <= req_addr;
                        cap_wdata <= req_wdata;
                        cap_wmask <= req_wmask;
                        if (delay != CW'(1)) begin
                            state <= BUSY;
                            cnt   <= delay - CW'(2);
                        end
                    end
                end
                BUSY: begin
                    if (cnt != '0) cnt <= cnt - CW'(1);
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: two responders (LATENCY 1 and 4) driven by directed and
// random transactions, checked against a byte-level storage model.
module tb_sram_responder;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int unsigned DL2  = 12;
    localparam int          LAT0 = 1;
    localparam int          LAT1 = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_wen   [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_wmask [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit outstanding [2];

    bit [31:0] model [longint];
    bit [3:0]  known [longint];

    always #5 clk = ~clk;

    // Cycle counter used for response spacing
    always @(posedge clk) cyc <= cyc + 1;

    sram_responder #(.ADDR_BASE(BASE), .DEPTH_LOG2(DL2), .LATENCY(LAT0)) u_lat1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wen(req_wen[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    sram_responder #(.ADDR_BASE(BASE), .DEPTH_LOG2(DL2), .LATENCY(LAT1)) u_lat4 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wen(req_wen[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int lat_of(input int u);
        return (u == 0) ? LAT0 : LAT1;
    endfunction

    function automatic int lat_max(input int u);
`ifdef SRAM_RESPONDER_RAND_DELAY_EN
        return lat_of(u) + 7;
`else
        return lat_of(u);
`endif
    endfunction

    function automatic bit in_rng(input logic [31:0] a);
        longint d;
        d = longint'({32'h0, a}) - longint'({32'h0, BASE});
        return (d >= 0) && (d < (longint'(4) << DL2));
    endfunction

    function automatic longint key_of(input int u, input logic [31:0] a);
        logic [31:0] w;
        w = (a - BASE) >> 2;
        return (longint'(u) << 32) | longint'({32'h0, w});
    endfunction

    function automatic logic [31:0] byte_mask(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    // A response may only be visible while a request is outstanding
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rst === 1'b0 && rsp_valid[u] === 1'b1)
                check_eq($sformatf("no_spurious_rsp%0d", u), 32'(outstanding[u]), 32'd1);
        end
    end

    task automatic do_txn(input int u, input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wmask, input int hold,
                          output logic [31:0] got_rdata, output logic got_err);
        int k;
        int lat;
        bit exp_err;
        longint key;
        logic [31:0] exp_rdata;
        logic [31:0] kmask;
        got_rdata = 'x;
        got_err   = 1'bx;
        @(negedge clk);
        req_valid[u] = 1'b1;
        req_wen[u]   = wen;
        req_addr[u]  = addr;
        req_wdata[u] = wdata;
        req_wmask[u] = wmask;
        k = 0;
        while (req_ready[u] !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) begin
            check_eq("req_ready_timeout", 32'd0, 32'd1);
            req_valid[u] = 1'b0;
            return;
        end
        @(posedge clk);
        outstanding[u] = 1'b1;
        @(negedge clk);
        // Garbage after the handshake must not influence the response
        req_valid[u] = 1'b0;
        req_wen[u]   = 1'($urandom);
        req_addr[u]  = $urandom;
        req_wdata[u] = $urandom;
        req_wmask[u] = 4'($urandom);
        lat = 1;
        while (rsp_valid[u] !== 1'b1 && lat <= lat_max(u) + 3) begin
            check_eq("busy_req_ready", 32'(req_ready[u]), 32'd0);
            @(negedge clk);
            lat++;
        end
        if (rsp_valid[u] !== 1'b1) begin
            check_eq("rsp_timeout", 32'd0, 32'd1);
            return;
        end
`ifdef SRAM_RESPONDER_RAND_DELAY_EN
        check_eq("latency_window", 32'(lat >= lat_of(u) && lat <= lat_max(u)), 32'd1);
`else
        check_eq("latency", 32'(lat), 32'(lat_of(u)));
`endif
        exp_err   = !in_rng(addr);
        exp_rdata = '0;
        kmask     = '0;
        key       = key_of(u, addr);
        if (!exp_err && !wen && model.exists(key)) begin
            exp_rdata = model[key];
            kmask     = byte_mask(known[key]);
        end
        got_rdata = rsp_rdata[u];
        got_err   = rsp_err[u];
        check_eq("rsp_err", 32'(got_err), 32'(exp_err));
        if (wen || exp_err) check_eq("rsp_rdata_zero", got_rdata, 32'h0);
        else if (kmask != '0) check_eq("rsp_rdata", got_rdata & kmask, exp_rdata & kmask);
        if (wen && !exp_err) begin
            if (!model.exists(key)) begin
                model[key] = '0;
                known[key] = '0;
            end
            model[key] = (model[key] & ~byte_mask(wmask)) | (wdata & byte_mask(wmask));
            known[key] = known[key] | wmask;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_valid", 32'(rsp_valid[u]), 32'd1);
            check_eq("hold_rdata", rsp_rdata[u], got_rdata);
            check_eq("hold_err", 32'(rsp_err[u]), 32'(got_err));
            check_eq("hold_req_ready", 32'(req_ready[u]), 32'd0);
        end
        rsp_ready[u] = 1'b1;
        @(posedge clk);
        outstanding[u] = 1'b0;
        @(negedge clk);
        rsp_ready[u] = 1'b0;
        check_eq("valid_after_accept", 32'(rsp_valid[u]), 32'd0);
        check_eq("ready_after_accept", 32'(req_ready[u]), 32'd1);
    endtask

    task automatic back_to_back(input int u);
        int times [$];
        @(negedge clk);
        outstanding[u] = 1'b1;
        rsp_ready[u]   = 1'b1;
        req_valid[u]   = 1'b1;
        req_wen[u]     = 1'b0;
        req_addr[u]    = BASE + 32'h10;
        for (int i = 0; i < 30 + lat_of(u) + 3; i++) begin
            if (i == 30) req_valid[u] = 1'b0;
            @(negedge clk);
            if (rsp_valid[u] === 1'b1) begin
                times.push_back(cyc);
                check_eq("b2b_rdata", rsp_rdata[u], 32'hDEAA_BEEF);
            end
        end
        rsp_ready[u]   = 1'b0;
        outstanding[u] = 1'b0;
        check_eq("b2b_count", 32'(times.size() >= 5), 32'd1);
        for (int i = 1; i < times.size(); i++)
            check_eq("b2b_period", 32'(times[i] - times[i-1]), 32'(lat_of(u) + 1));
    endtask

    task automatic check_reset_outputs();
        for (int u = 0; u < 2; u++) begin
            check_eq("rst_req_ready", 32'(req_ready[u]), 32'd0);
            check_eq("rst_rsp_valid", 32'(rsp_valid[u]), 32'd0);
            check_eq("rst_rsp_rdata", rsp_rdata[u], 32'h0);
            check_eq("rst_rsp_err", 32'(rsp_err[u]), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic        e;
        int          k;
        logic [31:0] a;
        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b0; req_wen[u] = 1'b0; req_addr[u] = '0;
            req_wdata[u] = '0;   req_wmask[u] = '0; rsp_ready[u] = 1'b0;
            outstanding[u] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;

        for (int u = 0; u < 2; u++) begin
            do_txn(u, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, r, e);
            check_eq("wr_err", 32'(e), 32'd0);
            do_txn(u, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, r, e);
            check_eq("rd_deadbeef", r, 32'hDEAD_BEEF);
            check_eq("rd_deadbeef_err", 32'(e), 32'd0);
            do_txn(u, 1'b1, 32'h8000_0012, 32'h00AA_0000, 4'b0100, 0, r, e);
            do_txn(u, 1'b0, 32'h8000_0012, 32'h0, 4'h0, 0, r, e);
            check_eq("rd_merged", r, 32'hDEAA_BEEF);
            do_txn(u, 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 0, r, e);
            check_eq("mask0_err", 32'(e), 32'd0);
            do_txn(u, 1'b1, 32'h8000_4010, 32'h0000_0000, 4'hF, 0, r, e);
            check_eq("oob_wr_err", 32'(e), 32'd1);
            do_txn(u, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 0, r, e);
            check_eq("oob_lo_err", 32'(e), 32'd1);
            check_eq("oob_lo_rdata", r, 32'h0);
            do_txn(u, 1'b0, 32'h8000_4000, 32'h0, 4'h0, 0, r, e);
            check_eq("oob_hi_err", 32'(e), 32'd1);
            check_eq("oob_hi_rdata", r, 32'h0);
            do_txn(u, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 5, r, e);
            check_eq("rd_after_oob", r, 32'hDEAA_BEEF);
            check_eq("rd_after_oob_err", 32'(e), 32'd0);
        end

`ifndef SRAM_RESPONDER_RAND_DELAY_EN
        back_to_back(0);
        back_to_back(1);
`endif

        // Reset while a write sits uncommitted in BUSY on the LATENCY=4 unit
        do_txn(1, 1'b1, 32'h8000_0020, 32'h1111_1111, 4'hF, 0, r, e);
        @(negedge clk);
        req_valid[1] = 1'b1; req_wen[1] = 1'b1; req_addr[1] = 32'h8000_0020;
        req_wdata[1] = 32'h1234_5678; req_wmask[1] = 4'hF;
        k = 0;
        while (req_ready[1] !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_eq("rst_test_ready", 32'(req_ready[1]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        rst = 1'b1;
        check_eq("busy_valid_low", 32'(rsp_valid[1]), 32'd0);
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("dropped_rsp_valid", 32'(rsp_valid[1]), 32'd0);
        end
        do_txn(1, 1'b0, 32'h8000_0020, 32'h0, 4'h0, 0, r, e);
        check_eq("dropped_write", r, 32'h1111_1111);
        do_txn(1, 1'b0, 32'h8000_0012, 32'h0, 4'h0, 0, r, e);
        check_eq("persist_after_rst", r, 32'hDEAA_BEEF);

        // Random traffic against the storage model
        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 9);
            if (k == 0)      a = BASE - 32'(4 * $urandom_range(1, 4));
            else if (k == 1) a = BASE + 32'h4000 + 32'(4 * $urandom_range(0, 3));
            else if (k == 2) a = BASE + 32'h3FFC + 32'($urandom_range(0, 3));
            else             a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            do_txn(n % 2, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom),
                   $urandom_range(0, 3), r, e);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
